// File: rtl/scandoubler_if.sv
// rtl/scandoubler_if.sv - 15 kHz core video in, doubled 31 kHz video out
interface scandoubler_if;
    logic       ce_in;
    logic [5:0] red_in;
    logic [5:0] green_in;
    logic [5:0] blue_in;
    logic       hs_in;
    logic       vs_in;
    logic [5:0] red_out;
    logic [5:0] green_out;
    logic [5:0] blue_out;
    logic       hs_out;
    logic       vs_out;

    modport master (
        output ce_in, red_in, green_in, blue_in, hs_in, vs_in,
        input  red_out, green_out, blue_out, hs_out, vs_out
    );

    modport slave (
        input  ce_in, red_in, green_in, blue_in, hs_in, vs_in,
        output red_out, green_out, blue_out, hs_out, vs_out
    );
endinterface

// File: rtl/scandoubler.sv
// rtl/scandoubler.sv - ping-pong line buffer replaying each input line twice at pclk rate
module scandoubler #(
    parameter int LINE_MAX = 1024
) (
    input  logic         pclk,
    input  logic         reset,
    input  logic         disable_scandoubler,
    input  logic         scanlines,
    scandoubler_if.slave vid
);
    localparam int AW = $clog2(LINE_MAX);
    localparam logic [AW-1:0] LAST = AW'(LINE_MAX - 1);

    logic [17:0]   mem [0:2*LINE_MAX-1];
    logic [17:0]   pix_in;
    logic          line_start;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;

    logic          hs_prev;
    logic [AW-1:0] hcnt_in;
    logic          wbank;
    logic [AW:0]   line_len;
    logic [AW-1:0] sync_cnt;
    logic [AW-1:0] sync_len;
    logic          started;
    logic          valid;
    logic          vs_cur;
    logic          vs_line;

    logic [AW-1:0] hcnt_out;
    logic          second;
    logic [17:0]   rd_data;
    logic          hs_d1;
    logic          vs_d1;
    logic          second_d1;
    logic          valid_d1;
    logic [17:0]   rgb_gen;

    assign pix_in     = {vid.red_in, vid.green_in, vid.blue_in};
    assign line_start = vid.ce_in & hs_prev & ~vid.hs_in;

    // The line-start pixel is pixel 0 of the new line, so it already goes to the new bank.
    assign wr_bank = line_start ? ~wbank : wbank;
    assign wr_addr = line_start ? '0 : ((hcnt_in == LAST) ? hcnt_in : hcnt_in + 1'b1);

    always_ff @(posedge pclk) begin
        if (vid.ce_in) begin
            mem[{wr_bank, wr_addr}] <= pix_in;
        end
        rd_data <= mem[{~wbank, hcnt_out}];
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            hs_prev  <= 1'b1;
            hcnt_in  <= '0;
            wbank    <= 1'b0;
            line_len <= '0;
            sync_cnt <= '0;
            sync_len <= '0;
            started  <= 1'b0;
            valid    <= 1'b0;
            vs_cur   <= 1'b1;
            vs_line  <= 1'b1;
        end else if (vid.ce_in) begin
            hs_prev <= vid.hs_in;
            if (line_start) begin
                line_len <= {1'b0, hcnt_in} + 1'b1;
                hcnt_in  <= '0;
                wbank    <= ~wbank;
                sync_cnt <= AW'(1);
                started  <= 1'b1;
                // vs travels with the line it was sampled on, so it reaches the pins with that line's replay.
                vs_cur   <= vid.vs_in;
                vs_line  <= vs_cur;
                // The first line after reset is partial and never unlocks the output.
                if (started && hcnt_in != '0) begin
                    valid <= 1'b1;
                end
            end else begin
                hcnt_in <= wr_addr;
                if (!vid.hs_in && sync_cnt != LAST) begin
                    sync_cnt <= sync_cnt + 1'b1;
                end
                if (!hs_prev && vid.hs_in) begin
                    sync_len <= sync_cnt;
                end
            end
        end
    end

    always_comb begin
        rgb_gen = rd_data;
        if (scanlines && second_d1) begin
            rgb_gen = {1'b0, rd_data[17:13], 1'b0, rd_data[11:7], 1'b0, rd_data[5:1]};
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            hcnt_out      <= '0;
            second        <= 1'b0;
            hs_d1         <= 1'b1;
            vs_d1         <= 1'b1;
            second_d1     <= 1'b0;
            valid_d1      <= 1'b0;
            vid.red_out   <= '0;
            vid.green_out <= '0;
            vid.blue_out  <= '0;
            vid.hs_out    <= 1'b1;
            vid.vs_out    <= 1'b1;
        end else begin
            if (line_start) begin
                hcnt_out <= '0;
                second   <= 1'b0;
            end else if ({1'b0, hcnt_out} == line_len - 1'b1) begin
                hcnt_out <= '0;
                second   <= 1'b1;
            end else begin
                hcnt_out <= hcnt_out + 1'b1;
            end

            hs_d1     <= (hcnt_out >= sync_len);
            vs_d1     <= vs_line;
            second_d1 <= second;
            valid_d1  <= valid;

            if (disable_scandoubler) begin
                vid.red_out   <= vid.red_in;
                vid.green_out <= vid.green_in;
                vid.blue_out  <= vid.blue_in;
                vid.hs_out    <= vid.hs_in;
                vid.vs_out    <= vid.vs_in;
            end else if (!valid_d1) begin
                vid.red_out   <= '0;
                vid.green_out <= '0;
                vid.blue_out  <= '0;
                vid.hs_out    <= 1'b1;
                vid.vs_out    <= 1'b1;
            end else begin
                vid.red_out   <= rgb_gen[17:12];
                vid.green_out <= rgb_gen[11:6];
                vid.blue_out  <= rgb_gen[5:0];
                vid.hs_out    <= hs_d1;
                vid.vs_out    <= vs_d1;
            end
        end
    end
endmodule

// File: tb/tb_scandoubler.sv
// tb/tb_scandoubler.sv - randomized line-level reference checks for scandoubler
module tb_scandoubler;
    localparam int HSW = 30;
    localparam int LMAX = 1024;
    localparam logic [19:0] IDLE = {18'd0, 2'b11};

    logic pclk = 1'b0;
    logic reset = 1'b1;
    logic dis = 1'b0;
    logic scan = 1'b0;

    scandoubler_if vid();

    scandoubler #(.LINE_MAX(LMAX)) dut (
        .pclk                (pclk),
        .reset               (reset),
        .disable_scandoubler (dis),
        .scanlines           (scan),
        .vid                 (vid)
    );

    always #5 pclk = ~pclk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: every input line is stored whole; line 0 is the partial line after reset.
    int          e = 0;
    int          li = 0;
    int          start_edge [32];
    int          llen [32];
    logic        vsl [32];
    logic [17:0] lpix [32][1200];
    logic        hs_prev_m = 1'b1;
    bit          glitch = 1'b0;
    logic [19:0] obs_q [$];
    logic [19:0] exp_q [$];
    int          rst_idx = -1;

    task automatic tick(input bit ce, input logic [17:0] pix, input logic hs,
                        input logic vs, input bit rst);
        logic [19:0] expv;
        logic [17:0] px;
        logic [5:0]  cr, cg, cb;
        int k, r, m, len_c, i;
        reset        = rst;
        vid.ce_in    = ce;
        vid.red_in   = pix[17:12];
        vid.green_in = pix[11:6];
        vid.blue_in  = pix[5:0];
        vid.hs_in    = hs;
        vid.vs_in    = vs;
        @(posedge pclk);
        e++;
        expv = IDLE;
        if (rst) begin
            li = 0;
            llen[0] = 0;
            start_edge[0] = 0;
            hs_prev_m = 1'b1;
        end else begin
            if (ce) begin
                if (hs_prev_m && !hs && li < 31) begin
                    li++;
                    start_edge[li] = e;
                    llen[li] = 0;
                    vsl[li] = vs;
                end
                if (llen[li] < 1200) lpix[li][llen[li]] = pix;
                llen[li]++;
                hs_prev_m = hs;
            end
            if (dis) begin
                expv = {pix, hs, vs};
            end else begin
                k = 0;
                for (int j = 1; j <= li; j++) if (start_edge[j] <= e - 2) k = j;
                if (k >= 2 && llen[k-1] >= 2) begin
                    r     = k - 1;
                    m     = e - 2 - start_edge[k];
                    len_c = (llen[r] > LMAX) ? LMAX : llen[r];
                    i     = m % len_c;
                    px    = lpix[r][(i == LMAX - 1) ? llen[r] - 1 : i];
                    cr = px[17:12];
                    cg = px[11:6];
                    cb = px[5:0];
                    if (scan && m >= len_c) begin
                        cr = cr / 2;
                        cg = cg / 2;
                        cb = cb / 2;
                    end
                    expv = {cr, cg, cb, (i >= HSW), vsl[r]};
                end
            end
        end
        #1;
        obs_q.push_back({vid.red_out, vid.green_out, vid.blue_out, vid.hs_out, vid.vs_out});
        exp_q.push_back(expv);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 18'd0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic drive_idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick(1'b1, 18'd0, 1'b1, 1'b1, 1'b0);
            tick(1'b0, 18'd0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic drive_line(input int len, input logic vs, input int mode, input int rst_at);
        logic [17:0] pix;
        logic hs;
        for (int k = 0; k < len; k++) begin
            case (mode)
                0:       pix = {3{6'(k % 64)}};
                1:       pix = {3{6'd62}};
                default: pix = 18'($urandom);
            endcase
            hs = (k < HSW) ? 1'b0 : 1'b1;
            if (k == rst_at) rst_idx = obs_q.size();
            tick(1'b1, pix, hs, vs, k == rst_at);
            tick(1'b0, 18'($urandom), glitch ? 1'($urandom) : hs, vs, 1'b0);
        end
    endtask

    task automatic test_reset;
        dis = 1'b0;
        scan = 1'b0;
        do_reset(4);
        drive_idle(4);
        for (int i = 0; i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== IDLE) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, obs_q[i], IDLE);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_basic_doubling;
        dis = 1'b0;
        scan = 1'b0;
        do_reset(4);
        drive_idle(10);
        for (int l = 0; l < 6; l++) drive_line(400, 1'b1, 0, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL basic_doubling cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_scanlines;
        dis = 1'b0;
        scan = 1'b1;
        do_reset(4);
        drive_idle(10);
        for (int l = 0; l < 4; l++) drive_line(400, 1'b1, 1, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL scanlines cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        scan = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random_lines;
        dis = 1'b0;
        scan = 1'($urandom);
        glitch = 1'b1;
        do_reset(4);
        drive_idle(10);
        for (int l = 0; l < 6; l++) drive_line($urandom_range(100, 600), 1'($urandom), 2, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL random_lines cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        glitch = 1'b0;
        scan = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_overflow;
        dis = 1'b0;
        scan = 1'b0;
        do_reset(4);
        drive_idle(10);
        for (int l = 0; l < 4; l++) drive_line(1100, 1'b1, 2, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL overflow cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_line;
        dis = 1'b0;
        scan = 1'b0;
        rst_idx = -1;
        do_reset(4);
        drive_idle(10);
        for (int l = 1; l <= 8; l++) drive_line(400, 1'b1, 0, (l == 5) ? 200 : -1);
        vectors++;
        if (rst_idx < 0 || obs_q[rst_idx] !== IDLE) begin
            miscompares++;
            $display("FAIL reset_mid_line_idle: got %h expected %h",
                     (rst_idx < 0) ? 20'hx : obs_q[rst_idx], IDLE);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL reset_mid_line cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_vsync;
        int vs_low;
        dis = 1'b0;
        scan = 1'b0;
        do_reset(4);
        drive_idle(10);
        for (int l = 1; l <= 8; l++) drive_line(400, (l >= 3 && l <= 5) ? 1'b0 : 1'b1, 2, -1);
        vs_low = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i][0] === 1'b0) vs_low++;
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL vsync cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        // Three input lines of 400 pixels become six 400-pclk output lines.
        vectors++;
        if (vs_low !== 6 * 400) begin
            miscompares++;
            $display("FAIL vsync_low_cycles: got %0d expected %0d", vs_low, 6 * 400);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_bypass;
        dis = 1'b1;
        scan = 1'($urandom);
        do_reset(2);
        for (int k = 0; k < 3000; k++)
            tick(1'($urandom), 18'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bypass cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        dis = 1'b0;
        scan = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vid.ce_in    = 1'b0;
        vid.red_in   = '0;
        vid.green_in = '0;
        vid.blue_in  = '0;
        vid.hs_in    = 1'b1;
        vid.vs_in    = 1'b1;
        test_reset();
        test_basic_doubling();
        test_scanlines();
        test_random_lines();
        test_overflow();
        test_reset_mid_line();
        test_vsync();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/scandoubler.md
# scandoubler

Line-doubling stage that sits directly upstream of the OSD overlay. It takes the core's 15 kHz RGB video, sampled on a pixel-enable at half the `pclk` rate, and stores each line in a ping-pong line buffer. It then replays the previous line twice at full `pclk` rate, producing 31 kHz VGA-compatible video with optional scanline dimming. Its outputs drive the OSD video inputs directly. A bypass mode passes the 15 kHz video through with one register of delay.

## Interface
- `LINE_MAX`, default 1024: line-buffer depth per bank, in input pixels; must be a power of two.
- `pclk` input, 1 bit: the single clock, at 2× the core pixel rate.
- `reset` input, 1 bit: synchronous, active-high.
- `ce_in` input, 1 bit: input pixel strobe; nominally asserted every second `pclk`.
- `disable_scandoubler` input, 1 bit: 1 selects bypass mode.
- `scanlines` input, 1 bit: 1 halves RGB on the second replay of each line.
- `red_in`, `green_in`, `blue_in` input, 6 bits each: core video.
- `hs_in`, `vs_in` input, 1 bit each: core syncs, active-low.
- `red_out`, `green_out`, `blue_out` output, 6 bits each: registered video to the OSD.
- `hs_out`, `vs_out` output, 1 bit each: registered syncs, active-low.

## Operation
- **Input side.** All input-side logic acts only on `pclk` edges where `ce_in`=1.
  - `hs_in`, sampled under `ce_in`, is compared with its previous sample. A 1→0 transition is the line start.
  - `hcnt_in` counts 0…LINE_MAX-1 and saturates at LINE_MAX-1.
  - Each strobe writes {r,g,b} (18 bits) to bank `wbank`, address `hcnt_in`. When saturated, writes go to the last address.
  - At line start:
    - `line_len` ← `hcnt_in`+1 (clipped to LINE_MAX).
    - `hcnt_in` ← 0.
    - `wbank` toggles.
    - `vs_line` ← sampled `vs_in`.
    - `valid` ← 1 once `line_len` ≥ 2.
  - `sync_len` counts strobes from line start while `hs_in`=0 and latches on the 0→1 edge of `hs_in`.
- **Output side.** Output-side logic runs every `pclk`.
  - `hcnt_out` reads bank ~`wbank`.
  - At input line start (the same cycle the input side detects it), `hcnt_out` ← 0 and `second` ← 0.
  - Otherwise, when `hcnt_out` = `line_len`-1: `hcnt_out` ← 0 and `second` ← 1.
  - Otherwise `hcnt_out` increments. After `second`=1 and a further wrap, it keeps wrapping with `second` held at 1 until the next line start, so a lagging source never stalls.
  - Sync generation: `hs_gen` = 0 while `hcnt_out` < `sync_len`; `vs_gen` = `vs_line`.
  - Video: `rgb_gen` = buffer data. If `scanlines`=1 and `second`=1, each channel is shifted right by 1 (e.g. 6'd63→6'd31).
- **Bypass.** With `disable_scandoubler`=1, every `pclk` registers the inputs straight to the outputs. The input-side logic keeps running so that switching modes needs no resync.
- **Before first lock.** While `valid`=0, outputs are RGB=0 and `hs_out`=`vs_out`=1.
- **Mode change.** `disable_scandoubler` is sampled every cycle. The change takes effect on the next output register update; glitching at the switch point is allowed.

## Timing
- **Reset values.**
  - Outputs: RGB=0, `hs_out`=1, `vs_out`=1.
  - Internal: `hcnt_in`=`hcnt_out`=0, `wbank`=0, `line_len`=0, `sync_len`=0, `valid`=0, `second`=0.
  - Buffer contents are undefined and are masked by `valid`=0.
  - Reset asserted mid-line takes effect on the next `pclk` and returns all of the above to reset values.
- **Read pipeline.** Address (cycle t), synchronous RAM read (t+1), output register (t+2). `hs_gen`/`vs_gen`/`second` are delayed 2 cycles so they stay aligned with RGB. Doubler latency from address to pins is 2 `pclk`.
- **Bypass latency.** 1 `pclk`.
- **Simultaneous write and read.** The write and read banks always differ, so no read-during-write hazard exists. A `wbank` toggle and an `hcnt_out` reset occurring in the same cycle are legal.
- **Input line longer than LINE_MAX.** The replay shows the first LINE_MAX-1 pixels and then repeats the last one.
- **Line start without `ce_in`.** Edges are only detected under `ce_in`, so `hs_in` glitches between strobes are ignored.

## Test plan
- **Basic doubling.** Reset 4 cycles, `ce_in` every other `pclk`, 400-pixel lines with 30-pixel `hs_in` low, pixel value = index mod 64 on all channels.
  - From the 2nd input line on, each input line yields two output lines of 400 `pclk`.
  - `hs_out` is low for 30 `pclk` at the start of each output line.
  - Pixel k on the pins equals k mod 64.
- **Scanlines.** Same stimulus as basic doubling, `scanlines`=1, constant input 6'd62.
  - The first replay outputs 62.
  - The second replay outputs 31.
- **Bypass.** `disable_scandoubler`=1 with random RGB and syncs.
  - Every output equals the input delayed exactly 1 `pclk`.
- **Overflow.** 1100-pixel lines with `LINE_MAX`=1024.
  - `line_len`=1024.
  - Output pixels 1023…1099 hold the value written at address 1023.
- **Reset mid-line.** Pulse `reset` at pixel 200 of line 5.
  - The next cycle shows RGB=0 and `hs_out`=`vs_out`=1.
  - Valid doubled output resumes 2 input lines later.
- **Vsync.** `vs_in` low for 3 input lines.
  - `vs_out` is low for exactly 6 output lines, delayed by 1 input line.
